fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the main decoder in the RISC-V core. It holds the program counter and fetches one instruction word from instruction memory over a req/ack handshake. It presents the instruction and its opcode field to the decoder, then computes the next PC from the decoder's `PCSrc` and the extended immediate when the core retires the instruction.

---
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V instruction fetch stage: PC, imem req/ack, next-PC select
// Optional FETCH_MISALIGN_TRAP_EN: halt with sticky misalign on an unaligned next PC.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic            instr_valid,
  input  logic            retire,
  input  logic            pc_src,
  input  logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0] S_HALT  = 2'd2;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]      state;
  logic [XLEN-1:0] next_pc;

  assign pc_plus4  = pc + XLEN'(4);
  assign next_pc   = pc_src ? (pc + imm_ext) : pc_plus4;
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign op        = instr[6:0];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (retire && instr_valid) begin
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            pc <= next_pc;
            if (next_pc[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
              state      <= S_HALT;
            end else begin
              state <= S_FETCH;
            end
`else
            // Unaligned targets are silently word-aligned when trapping is not built in.
            pc    <= next_pc & {{(XLEN-2){1'b1}}, 2'b00};
            state <= S_FETCH;
`endif
          end
        end
        default: begin
          // HALT: everything held until reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
// Expectations follow FETCH_MISALIGN_TRAP_EN when it is defined for the build.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  op;
  logic        instr_valid;
  logic        retire;
  logic        pc_src;
  logic [31:0] imm_ext;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .instr_valid(instr_valid),
    .retire(retire), .pc_src(pc_src), .imm_ext(imm_ext),
    .pc(pc), .pc_plus4(pc_plus4), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory answers after 'delay' idle request cycles; the word is queued as the expected instr.
  task automatic fetch(input logic [31:0] word, input int delay);
    logic [31:0] held;
    logic [31:0] exp_w;
    held = instr;
    for (int i = 0; i < delay; i++) begin
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_instr", instr, held);
      step();
    end
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_q.push_back(word);
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      exp_w = exp_q.pop_front();
      chk("valid", {31'b0, instr_valid}, 32'd1);
      chk("instr", instr, exp_w);
      chk("op", {25'b0, op}, {25'b0, exp_w[6:0]});
      chk("exec_req", {31'b0, imem_req}, 32'd0);
    end
  endtask

  task automatic do_retire(input logic src, input logic [31:0] imm, input logic [31:0] nxt);
    retire  = 1'b1;
    pc_src  = src;
    imm_ext = imm;
    step();
    retire  = 1'b0;
    pc_src  = 1'b0;
    imm_ext = 32'h0;
    exp_pc  = nxt;
    chk("retire_pc", pc, nxt);
    chk("retire_addr", imem_addr, nxt);
    chk("retire_req", {31'b0, imem_req}, 32'd1);
    chk("retire_valid", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    retire = 1'b0; pc_src = 1'b0; imm_ext = 32'h0;
    exp_pc = 32'h0;
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    rst = 1'b0;

    fetch(32'h0000_0033, 0);
    chk("op_rtype", {25'b0, op}, 32'h33);
    do_retire(1'b1, 32'h0000_0100, 32'h0000_0100);

    fetch(32'h0050_0093, 3);
    do_retire(1'b1, 32'hFFFF_FFF8, 32'h0000_00F8);
    fetch(32'h0000_0013, 1);
    do_retire(1'b1, 32'h0000_0008, 32'h0000_0100);
    fetch(32'h0020_8133, 0);
    do_retire(1'b0, 32'h1234_5678, 32'h0000_0104);

    fetch(32'h0000_0063, 2);
    do_retire(1'b1, 32'hFFFF_FEF8, 32'hFFFF_FFFC);
    chk("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
    fetch(32'h0000_0013, 0);
    do_retire(1'b0, 32'h0, 32'h0000_0000);

    // Retire pulse while still fetching must be ignored.
    retire = 1'b1; pc_src = 1'b1; imm_ext = 32'h40;
    step();
    retire = 1'b0; pc_src = 1'b0; imm_ext = 32'h0;
    chk("fetch_retire_pc", pc, 32'h0000_0000);
    chk("fetch_retire_req", {31'b0, imem_req}, 32'd1);

    fetch(32'h0000_0013, 0);
    do_retire(1'b1, 32'h0000_0100, 32'h0000_0100);
    fetch(32'h0000_0063, 0);

    retire = 1'b1; pc_src = 1'b1; imm_ext = 32'h2;
    step();
    retire = 1'b0; pc_src = 1'b0; imm_ext = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_pc", pc, 32'h0000_0102);
    chk("trap_misalign", {31'b0, misalign}, 32'd1);
    chk("trap_req", {31'b0, imem_req}, 32'd0);
    imem_ack = 1'b1; retire = 1'b1;
    step();
    step();
    imem_ack = 1'b0; retire = 1'b0;
    chk("halt_req", {31'b0, imem_req}, 32'd0);
    chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    chk("halt_misalign", {31'b0, misalign}, 32'd1);
    chk("halt_pc", pc, 32'h0000_0102);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_pc = 32'h0;
    step();
`else
    chk("align_pc", pc, 32'h0000_0100);
    chk("align_misalign", {31'b0, misalign}, 32'd0);
    chk("align_req", {31'b0, imem_req}, 32'd1);
    exp_pc = 32'h0000_0100;
`endif

    fetch(32'h00A0_0513, 1);
    // Asynchronous reset mid-EXEC, sampled well before the next clock edge.
    rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_instr", instr, 32'h0000_0013);
    chk("arst_valid", {31'b0, instr_valid}, 32'd0);
    chk("arst_req", {31'b0, imem_req}, 32'd1);
    #2;
    rst = 1'b0;
    step();
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
